// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid stage: FSM encoding,
// default parameter values and the state-to-occupancy mapping.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_CTRL_W          = 8;
    localparam int DEF_FLUSH_ZERO_DATA = 1;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ST_FULL: occ_of = 2'd1;
            ST_SKID: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load, clear of the low-order control bits, and clear of
// the whole payload. Clears take priority over load.
module pipe_data_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic              clr_all,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Ones in the control field; all-zero when CTRL_W is 0.
    localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr_all)
            q <= '0;
        else if (clr_ctrl)
            q <= q & ~CTRL_MASK;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer for a valid/ready pipeline stage with a flush that
// kills held entries; in_ready and out_valid come straight from flops.
//
//   state    | meaning
//   ST_EMPTY | nothing held, occupancy 0
//   ST_FULL  | main valid, occupancy 1
//   ST_SKID  | main and skid valid, occupancy 2, upstream stalled
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int CTRL_W          = DEF_CTRL_W,
    parameter int FLUSH_ZERO_DATA = DEF_FLUSH_ZERO_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_t            state, state_nxt;
    logic              accept, drain;
    logic              main_load, main_from_skid, skid_load;
    logic              in_ready_nxt, out_valid_nxt;
    logic [1:0]        occ_nxt;
    logic [DATA_W-1:0] main_q, skid_q, main_d;
    logic              clr_all;

    assign accept  = in_valid & in_ready;
    assign drain   = out_valid & out_ready;
    assign clr_all = flush & (FLUSH_ZERO_DATA != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            occupancy <= occ_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_EMPTY;
        else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (drain && !accept)
                        state_nxt = ST_EMPTY;
                    else if (accept && !drain)
                        state_nxt = ST_SKID;
                end
                ST_SKID:  if (drain) state_nxt = ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_FULL: begin
                    main_load = accept & drain;
                    skid_load = accept & ~drain;
                end
                ST_SKID: begin
                    main_load      = drain;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
        in_ready_nxt  = (state_nxt != ST_SKID);
        out_valid_nxt = (state_nxt != ST_EMPTY);
        occ_nxt       = occ_of(state_nxt);
    end

    assign main_d   = main_from_skid ? skid_q : in_data;
    assign out_data = main_q;

    pipe_data_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clr_ctrl (flush),
        .clr_all  (clr_all),
        .d        (main_d),
        .q        (main_q)
    );

    pipe_data_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clr_ctrl (flush),
        .clr_all  (clr_all),
        .d        (in_data),
        .q        (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random stress, checked
// against a FIFO-queue reference model of the stage.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q[$];
    bit          main_cleared;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .FLUSH_ZERO_DATA(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0)
            chk("out_data", out_data, q[0]);
        else if (main_cleared)
            chk("cleared_data", out_data, 32'h0);
    endtask

    // Drive one cycle at the negedge, advance the model, check after the edge.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        bit acc, drn;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        acc = iv && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        if (r || f) begin
            q.delete();
            main_cleared = 1'b1;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(d);
                main_cleared = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        main_cleared = 1'b1;
        @(negedge clk);

        // Reset with garbage on the input side.
        cycle(1, 0, 1, 32'hDEADBEEF, 0);
        cycle(1, 0, 1, 32'hDEADBEEF, 0);
        chk("reset_out_data", out_data, 32'h0);

        // Streaming at full throughput, first accept right after reset.
        cycle(0, 0, 1, 32'h1, 1);
        chk("stream_first", out_data, 32'h1);
        cycle(0, 0, 1, 32'h2, 1);
        cycle(0, 0, 1, 32'h3, 1);
        cycle(0, 0, 0, 32'h0, 1);
        chk("stream_drained", 32'(out_valid), 32'h0);

        // Back-pressure into the skid entry, then release.
        cycle(0, 0, 1, 32'hA, 0);
        cycle(0, 0, 1, 32'hB, 0);
        chk("bp_occ2", 32'(occupancy), 32'd2);
        cycle(0, 0, 1, 32'hC, 0);
        cycle(0, 0, 0, 32'h0, 1);
        chk("bp_second", out_data, 32'hB);
        cycle(0, 0, 0, 32'h0, 1);
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Flush while in SKID with an input offered.
        cycle(0, 0, 1, 32'h1FF, 0);
        cycle(0, 0, 1, 32'h2AA, 0);
        cycle(0, 1, 1, 32'h77, 0);
        chk("flush_ctrl_byte", 32'(out_data[7:0]), 32'h0);
        chk("flush_occ", 32'(occupancy), 32'h0);

        // Flush with drain; 0x55 must be discarded.
        cycle(0, 0, 1, 32'h44, 0);
        chk("pre_flush_drain", out_data, 32'h44);
        cycle(0, 1, 1, 32'h55, 1);
        cycle(0, 0, 0, 32'h0, 1);
        chk("no_55", 32'(out_valid), 32'h0);

        // Random stress.
        for (int i = 0; i < 10000; i++) begin
            cycle(0, ($urandom_range(99) < 5), $urandom_range(1), $urandom, $urandom_range(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
Parameters:
- REQ-001 DATA_W, default 32, payload width in bits; legal range 1..256.
- REQ-002 CTRL_W, default 8, number of low-order payload bits that are control (write enables, selects); legal range 0..DATA_W.
- REQ-003 FLUSH_ZERO_DATA, default 1; 1 = flush zeroes the whole payload, 0 = flush zeroes only the control bits.

Ports (name, direction, width, meaning):
- REQ-004 clk, input, 1, single clock; all state updates on its rising edge.
- REQ-005 rst, input, 1, reset: synchronous, active-high.
- REQ-006 flush, input, 1, synchronous kill of all held entries (branch mispredict or jump redirect).
- REQ-007 in_valid, input, 1, upstream stage presents a payload.
- REQ-008 in_ready, output, 1, this stage can accept a payload; registered.
- REQ-009 in_data, input, DATA_W, upstream payload; bits [CTRL_W-1:0] are control.
- REQ-010 out_valid, output, 1, the payload on out_data is valid.
- REQ-011 out_ready, input, 1, downstream stage accepts a payload (stall when 0).
- REQ-012 out_data, output, DATA_W, registered payload to the downstream stage.
- REQ-013 occupancy, output, 2, number of held entries (0, 1 or 2).

Function
- REQ-014 An input handshake (accept) is in_valid AND in_ready; an output handshake (drain) is out_valid AND out_ready.
- REQ-015 The block holds two storage entries, main and skid, and a three-state FSM: EMPTY (occupancy 0), FULL (main valid, occupancy 1), SKID (main and skid valid, occupancy 2).
- REQ-016 out_valid is 1 in FULL and SKID; out_data always equals the main entry.
- REQ-017 in_ready is 1 in EMPTY and FULL, and 0 in SKID; it is derived from registered state only, with no combinational path from out_ready.
- REQ-018 EMPTY transitions:
  - accept: main captures in_data, next state FULL. Latency from accept to out_valid is exactly 1 cycle.
  - otherwise: remain EMPTY.
- REQ-019 FULL transitions:
  - drain and accept: main captures in_data, remain FULL.
  - drain only: go to EMPTY.
  - accept without drain: skid captures in_data, go to SKID.
  - neither: hold.
- REQ-020 SKID transitions:
  - drain: main captures the skid entry, go to FULL.
  - otherwise: hold both entries.
  - No accept is possible in this state.
- REQ-021 Ordering is strictly FIFO. No payload is lost or duplicated, with or without back-pressure.
- REQ-022 flush has priority over every handshake:
  - next state is EMPTY and in_ready is 1 next cycle;
  - an accept in the flush cycle is discarded;
  - a drain in the flush cycle still completes downstream (out_data is stable that cycle).
- REQ-023 On flush, the control bits of main and skid go to 0. The data bits also go to 0 when FLUSH_ZERO_DATA=1 and are left unchanged otherwise.
- REQ-024 While out_valid is 1 and out_ready is 0, out_data stays stable cycle to cycle (no flush present).
- REQ-025 With CTRL_W=0, flush clears only the valid state.
- REQ-026 A transfer (pass-through) occurs every cycle at full throughput when out_ready is held at 1.

Reset
- REQ-027 While rst is 1 at a rising edge, the next state is:
  - FSM EMPTY, occupancy 0;
  - out_valid 0, in_ready 1;
  - main and skid payloads all-zero, regardless of FLUSH_ZERO_DATA.
- REQ-028 rst has priority over flush and over all handshakes. Entries held when reset is asserted mid-operation are discarded.
- REQ-029 The first accept is possible in the first cycle after rst deasserts.

Structure
- REQ-030 The FSM state enumeration (EMPTY, FULL, SKID) and the default parameter constants reside in the shared package pipe_pkg.
- REQ-031 One sub-module, pipe_data_reg, is instantiated twice (main and skid). It is a DATA_W register with load, clear-control and clear-all inputs.
- REQ-032 The block shall replace the fixed ID/EX, EX/MEM and MEM/WB registers by setting DATA_W to each stage's concatenated payload.

Verification
- REQ-033 Reset: drive rst=1 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF.
  - Required: out_valid=0, in_ready=1, occupancy=0, out_data=0.
- REQ-034 Streaming: set out_ready=1 and send 0x1, 0x2, 0x3 back-to-back.
  - Required: the same values appear on out_data one cycle later, consecutively, with no bubbles.
- REQ-035 Back-pressure: with out_ready=0, send 0xA then 0xB.
  - Required: occupancy goes 1 then 2, and in_ready=0.
  - Then raise out_ready: required outputs are 0xA then 0xB, followed by out_valid=0.
- REQ-036 Flush in SKID with CTRL_W=8: hold 0x1FF and 0x2AA, then assert flush for one cycle with in_valid=1.
  - Required next cycle: out_valid=0, occupancy=0, in_ready=1, main control byte=0x00.
- REQ-037 Flush with drain: in FULL with out_ready=1, assert flush together with accept of 0x55.
  - Required: the old entry completes its drain, 0x55 never appears, and the state next cycle is EMPTY.
- REQ-038 Random stress: 10,000 cycles of random in_valid, out_ready and flush (5%).
  - Required: the scoreboard matches FIFO order and out_data is stable under stall.
